// File: rtl/reverse_engine_param.sv
`default_nettype none
// ============================================================================
// Module   : reverse_engine_param
// Purpose  : Element-reverses a memory buffer over burst read/write ports.
// Revision : 1.0 - initial release
// ============================================================================
module reverse_engine_param #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 24,
    parameter int BURST  = 16
) (
    input  logic                     axi_clk,
    input  logic                     axi_rst,
    input  logic                     cfg_start,
    input  logic [ADDR_W-1:0]        cfg_src_base,
    input  logic [ADDR_W-1:0]        cfg_dst_base,
    input  logic [LEN_W-1:0]         cfg_len,
    input  logic [1:0]               cfg_mode,
    output logic                     done,
    output logic                     err,
    output logic                     rd_cmd_vld,
    input  logic                     rd_cmd_rdy,
    output logic [ADDR_W-1:0]        rd_cmd_addr,
    output logic [$clog2(BURST):0]   rd_cmd_len,
    input  logic                     rd_dat_vld,
    input  logic [DATA_W-1:0]        rd_dat,
    output logic                     wr_cmd_vld,
    input  logic                     wr_cmd_rdy,
    output logic [ADDR_W-1:0]        wr_cmd_addr,
    output logic [$clog2(BURST):0]   wr_cmd_len,
    output logic                     wr_dat_vld,
    input  logic                     wr_dat_rdy,
    output logic [DATA_W-1:0]        wr_dat
);

    localparam int DB     = DATA_W / 8;
    localparam int LOG_DB = $clog2(DB);
    localparam int IW     = $clog2(BURST);
    localparam int CLW    = IW + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD_CMD = 3'd1,
        S_RD_DAT = 3'd2,
        S_WR_CMD = 3'd3,
        S_WR_DAT = 3'd4
    } state_t;

    state_t             state_q;
    logic [ADDR_W-1:0]  src_q;
    logic [ADDR_W-1:0]  dst_q;
    logic [1:0]         mode_q;
    logic [LEN_W-1:0]   rem_q;
    logic [LEN_W-1:0]   wcnt_q;
    logic [CLW-1:0]     chunk_q;
    logic [CLW-1:0]     beat_q;
    logic [DATA_W-1:0]  buf_q [BURST];

    logic               cfg_bad;
    logic               start_acc;
    logic               start_rej;
    logic [LEN_W-1:0]   len_words;
    logic [LEN_W-1:0]   rem_d;
    logic [ADDR_W-1:0]  src_d;
    logic [CLW-1:0]     chunk_d;
    logic [ADDR_W-1:0]  rd_addr_d;
    logic [ADDR_W-1:0]  wr_addr_d;
    logic [IW-1:0]      ridx;
    logic [DATA_W-1:0]  rev_src;
    logic [DATA_W-1:0]  rev_b;
    logic [DATA_W-1:0]  rev_h;
    logic [DATA_W-1:0]  rev_w;
    logic [DATA_W-1:0]  rev_word;

    // The next read command is computed from the live config in IDLE and from
    // the latched state when looping back after a write burst.
    always_comb begin
        cfg_bad   = (cfg_len == '0) || (cfg_len[LOG_DB-1:0] != '0) ||
                    (cfg_mode == 2'd3) || ((DB >> cfg_mode) == 0);
        start_acc = cfg_start && (state_q == S_IDLE) && !cfg_bad;
        start_rej = cfg_start && (state_q == S_IDLE) && cfg_bad;
        len_words = cfg_len >> LOG_DB;
        rem_d     = (state_q == S_IDLE) ? len_words : rem_q;
        src_d     = (state_q == S_IDLE) ? cfg_src_base : src_q;
        chunk_d   = (rem_d >= LEN_W'(BURST)) ? CLW'(BURST) : rem_d[CLW-1:0];
        rd_addr_d = src_d + (ADDR_W'(rem_d - LEN_W'(chunk_d)) << LOG_DB);
        wr_addr_d = dst_q + (ADDR_W'(wcnt_q) << LOG_DB);
        ridx      = (state_q == S_WR_CMD) ? IW'(chunk_q - CLW'(1))
                                          : IW'(chunk_q - CLW'(2) - beat_q);
        rev_src   = buf_q[ridx];
    end

    for (genvar k = 0; k < DB; k++) begin : g_byte
        assign rev_b[k*8 +: 8] = rev_src[(DB-1-k)*8 +: 8];
    end
    for (genvar k = 0; k < DB/2; k++) begin : g_half
        assign rev_h[k*16 +: 16] = rev_src[(DB/2-1-k)*16 +: 16];
    end
    for (genvar k = 0; k < DB/4; k++) begin : g_word
        assign rev_w[k*32 +: 32] = rev_src[(DB/4-1-k)*32 +: 32];
    end

    always_comb begin
        case (mode_q)
            2'd0:    rev_word = rev_b;
            2'd1:    rev_word = rev_h;
            default: rev_word = rev_w;
        endcase
    end

    always_ff @(posedge axi_clk) begin
        if (state_q == S_RD_DAT && rd_dat_vld) begin
            buf_q[beat_q[IW-1:0]] <= rd_dat;
        end
    end

    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            state_q     <= S_IDLE;
            done        <= 1'b1;
            err         <= 1'b0;
            rd_cmd_vld  <= 1'b0;
            rd_cmd_addr <= '0;
            rd_cmd_len  <= '0;
            wr_cmd_vld  <= 1'b0;
            wr_cmd_addr <= '0;
            wr_cmd_len  <= '0;
            wr_dat_vld  <= 1'b0;
            wr_dat      <= '0;
            src_q       <= '0;
            dst_q       <= '0;
            mode_q      <= '0;
            rem_q       <= '0;
            wcnt_q      <= '0;
            chunk_q     <= '0;
            beat_q      <= '0;
        end else begin
            err <= start_rej;
            case (state_q)
                S_IDLE: begin
                    if (start_acc) begin
                        src_q       <= cfg_src_base;
                        dst_q       <= cfg_dst_base;
                        mode_q      <= cfg_mode;
                        rem_q       <= len_words;
                        wcnt_q      <= '0;
                        done        <= 1'b0;
                        rd_cmd_vld  <= 1'b1;
                        rd_cmd_addr <= rd_addr_d;
                        rd_cmd_len  <= chunk_d;
                        chunk_q     <= chunk_d;
                        state_q     <= S_RD_CMD;
                    end
                end
                S_RD_CMD: begin
                    if (rd_cmd_rdy) begin
                        rd_cmd_vld <= 1'b0;
                        beat_q     <= '0;
                        state_q    <= S_RD_DAT;
                    end
                end
                S_RD_DAT: begin
                    if (rd_dat_vld) begin
                        if (beat_q == chunk_q - CLW'(1)) begin
                            beat_q      <= '0;
                            rem_q       <= rem_q - LEN_W'(chunk_q);
                            wr_cmd_vld  <= 1'b1;
                            wr_cmd_addr <= wr_addr_d;
                            wr_cmd_len  <= chunk_q;
                            state_q     <= S_WR_CMD;
                        end else begin
                            beat_q <= beat_q + CLW'(1);
                        end
                    end
                end
                S_WR_CMD: begin
                    if (wr_cmd_rdy) begin
                        wr_cmd_vld <= 1'b0;
                        wr_dat_vld <= 1'b1;
                        wr_dat     <= rev_word;
                        beat_q     <= '0;
                        state_q    <= S_WR_DAT;
                    end
                end
                S_WR_DAT: begin
                    // Beat j drains buf[chunk-1-j]; the next word is preloaded on each handshake.
                    if (wr_dat_rdy) begin
                        if (beat_q == chunk_q - CLW'(1)) begin
                            wr_dat_vld <= 1'b0;
                            wcnt_q     <= wcnt_q + LEN_W'(chunk_q);
                            if (rem_q == '0) begin
                                done    <= 1'b1;
                                state_q <= S_IDLE;
                            end else begin
                                rd_cmd_vld  <= 1'b1;
                                rd_cmd_addr <= rd_addr_d;
                                rd_cmd_len  <= chunk_d;
                                chunk_q     <= chunk_d;
                                state_q     <= S_RD_CMD;
                            end
                        end else begin
                            beat_q <= beat_q + CLW'(1);
                            wr_dat <= rev_word;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reverse_engine_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_reverse_engine_param
// Purpose  : Scoreboard bench with a burst memory model for reverse_engine_param.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reverse_engine_param;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int LEN_W  = 24;
    localparam int BURST  = 16;
    localparam int DB     = DATA_W / 8;
    localparam int CLW    = $clog2(BURST) + 1;
    localparam int MEMSZ  = 16384;

    logic               axi_clk;
    logic               axi_rst;
    logic               cfg_start;
    logic [ADDR_W-1:0]  cfg_src_base;
    logic [ADDR_W-1:0]  cfg_dst_base;
    logic [LEN_W-1:0]   cfg_len;
    logic [1:0]         cfg_mode;
    logic               done;
    logic               err;
    logic               rd_cmd_vld;
    logic               rd_cmd_rdy;
    logic [ADDR_W-1:0]  rd_cmd_addr;
    logic [CLW-1:0]     rd_cmd_len;
    logic               rd_dat_vld;
    logic [DATA_W-1:0]  rd_dat;
    logic               wr_cmd_vld;
    logic               wr_cmd_rdy;
    logic [ADDR_W-1:0]  wr_cmd_addr;
    logic [CLW-1:0]     wr_cmd_len;
    logic               wr_dat_vld;
    logic               wr_dat_rdy;
    logic [DATA_W-1:0]  wr_dat;

    reverse_engine_param #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .BURST(BURST)
    ) dut (
        .axi_clk(axi_clk), .axi_rst(axi_rst), .cfg_start(cfg_start),
        .cfg_src_base(cfg_src_base), .cfg_dst_base(cfg_dst_base),
        .cfg_len(cfg_len), .cfg_mode(cfg_mode), .done(done), .err(err),
        .rd_cmd_vld(rd_cmd_vld), .rd_cmd_rdy(rd_cmd_rdy),
        .rd_cmd_addr(rd_cmd_addr), .rd_cmd_len(rd_cmd_len),
        .rd_dat_vld(rd_dat_vld), .rd_dat(rd_dat),
        .wr_cmd_vld(wr_cmd_vld), .wr_cmd_rdy(wr_cmd_rdy),
        .wr_cmd_addr(wr_cmd_addr), .wr_cmd_len(wr_cmd_len),
        .wr_dat_vld(wr_dat_vld), .wr_dat_rdy(wr_dat_rdy), .wr_dat(wr_dat)
    );

    initial begin
        axi_clk = 1'b0;
        forever #5 axi_clk = ~axi_clk;
    end

    typedef struct { logic [ADDR_W-1:0] addr; logic [CLW-1:0] len; } cmd_t;
    typedef struct { logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; } beat_t;

    int          checks = 0;
    int          errors = 0;
    bit          bp_en  = 1'b0;
    logic [7:0]  mem [MEMSZ];
    cmd_t        exp_rd_q[$];
    cmd_t        exp_wrc_q[$];
    beat_t       exp_wd_q[$];
    cmd_t        pend_rd_q[$];
    int          pend_beat  = 0;
    int          rd_cmd_cnt = 0;
    int          wr_cmd_cnt = 0;
    logic [ADDR_W-1:0] wr_cur = '0;
    bit          stall_q = 1'b0;
    logic [DATA_W-1:0] stall_dat = '0;

    function automatic bit coin();
        return bp_en ? ($urandom_range(0, 9) < 3) : 1'b1;
    endfunction

    // Bus responder and scoreboard: inputs change and outputs are sampled on negedge.
    initial begin
        cmd_t c;
        beat_t b;
        logic [DATA_W-1:0] wd;
        rd_cmd_rdy = 1'b0; rd_dat_vld = 1'b0; rd_dat = '0;
        wr_cmd_rdy = 1'b0; wr_dat_rdy = 1'b0;
        forever begin
            @(negedge axi_clk);
            if (axi_rst) begin
                pend_rd_q.delete(); exp_rd_q.delete(); exp_wrc_q.delete(); exp_wd_q.delete();
                pend_beat = 0; stall_q = 1'b0;
                rd_cmd_rdy = 1'b0; rd_dat_vld = 1'b0; wr_cmd_rdy = 1'b0; wr_dat_rdy = 1'b0;
            end else begin
                if (stall_q) begin
                    checks++;
                    if (wr_dat_vld !== 1'b1 || wr_dat !== stall_dat) begin
                        errors++;
                        $display("FAIL wr_dat_stable: got vld=%0b dat=%h, want vld=1 dat=%h",
                                 wr_dat_vld, wr_dat, stall_dat);
                    end
                end
                if (pend_rd_q.size() > 0) begin
                    if (!bp_en || $urandom_range(0, 9) < 7) begin
                        for (int k = 0; k < DB; k++)
                            wd[k*8 +: 8] = mem[int'(pend_rd_q[0].addr) + pend_beat*DB + k];
                        rd_dat_vld = 1'b1; rd_dat = wd;
                        pend_beat++;
                        if (pend_beat == int'(pend_rd_q[0].len)) begin
                            void'(pend_rd_q.pop_front());
                            pend_beat = 0;
                        end
                    end else begin
                        rd_dat_vld = 1'b0;
                    end
                end else begin
                    rd_dat_vld = bp_en ? 1'($urandom_range(0, 1)) : 1'b0;
                    rd_dat     = $urandom;
                end
                rd_cmd_rdy = coin();
                if (rd_cmd_vld && rd_cmd_rdy) begin
                    rd_cmd_cnt++; checks++;
                    if (exp_rd_q.size() == 0) begin
                        errors++;
                        $display("FAIL rd_cmd: got addr=%h len=%0d, want no command", rd_cmd_addr, rd_cmd_len);
                    end else begin
                        c = exp_rd_q.pop_front();
                        if (rd_cmd_addr !== c.addr || rd_cmd_len !== c.len) begin
                            errors++;
                            $display("FAIL rd_cmd: got addr=%h len=%0d, want addr=%h len=%0d",
                                     rd_cmd_addr, rd_cmd_len, c.addr, c.len);
                        end
                    end
                    pend_rd_q.push_back('{rd_cmd_addr, rd_cmd_len});
                end
                wr_dat_rdy = coin();
                if (wr_dat_vld && wr_dat_rdy) begin
                    checks++;
                    if (exp_wd_q.size() == 0) begin
                        errors++;
                        $display("FAIL wr_dat: got addr=%h dat=%h, want no beat", wr_cur, wr_dat);
                    end else begin
                        b = exp_wd_q.pop_front();
                        if (wr_cur !== b.addr || wr_dat !== b.data) begin
                            errors++;
                            $display("FAIL wr_dat: got addr=%h dat=%h, want addr=%h dat=%h",
                                     wr_cur, wr_dat, b.addr, b.data);
                        end
                    end
                    for (int k = 0; k < DB; k++)
                        mem[(int'(wr_cur) + k) % MEMSZ] = wr_dat[k*8 +: 8];
                    wr_cur = wr_cur + ADDR_W'(DB);
                end
                stall_q   = wr_dat_vld && !wr_dat_rdy;
                stall_dat = wr_dat;
                wr_cmd_rdy = coin();
                if (wr_cmd_vld && wr_cmd_rdy) begin
                    wr_cmd_cnt++; checks++;
                    if (exp_wrc_q.size() == 0) begin
                        errors++;
                        $display("FAIL wr_cmd: got addr=%h len=%0d, want no command", wr_cmd_addr, wr_cmd_len);
                    end else begin
                        c = exp_wrc_q.pop_front();
                        if (wr_cmd_addr !== c.addr || wr_cmd_len !== c.len) begin
                            errors++;
                            $display("FAIL wr_cmd: got addr=%h len=%0d, want addr=%h len=%0d",
                                     wr_cmd_addr, wr_cmd_len, c.addr, c.len);
                        end
                    end
                    wr_cur = wr_cmd_addr;
                end
            end
        end
    end

    // Reference: full element reversal of the source buffer, bursts taken from the top.
    task automatic expect_run(input int src, input int dst, input int len, input int mode);
        int n, es, ne, rem, wc, ch;
        logic [7:0] ob [];
        logic [DATA_W-1:0] w;
        n = len / DB; es = 1 << mode; ne = len / es;
        ob = new[len];
        for (int p = 0; p < len; p++)
            ob[p] = mem[src + (ne - 1 - p / es) * es + (p % es)];
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < DB; k++) w[k*8 +: 8] = ob[i*DB + k];
            exp_wd_q.push_back('{ADDR_W'(dst + i*DB), w});
        end
        rem = n; wc = 0;
        while (rem > 0) begin
            ch = (rem > BURST) ? BURST : rem;
            exp_rd_q.push_back('{ADDR_W'(src + (rem - ch)*DB), CLW'(ch)});
            exp_wrc_q.push_back('{ADDR_W'(dst + wc*DB), CLW'(ch)});
            rem -= ch; wc += ch;
        end
    endtask

    task automatic launch(input int src, input int dst, input int len, input int mode);
        expect_run(src, dst, len, mode);
        @(negedge axi_clk);
        cfg_src_base = ADDR_W'(src); cfg_dst_base = ADDR_W'(dst);
        cfg_len = LEN_W'(len); cfg_mode = 2'(mode); cfg_start = 1'b1;
        @(negedge axi_clk);
        cfg_start = 1'b0;
        checks++;
        if (done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL start_ack: got done=%0b err=%0b, want done=0 err=0", done, err);
        end
    endtask

    task automatic wait_done(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge axi_clk);
            if (done === 1'b1) break;
        end
        checks++;
        if (i == budget) begin
            errors++;
            $display("FAIL run_timeout: got done=%0b after %0d cycles, want done=1", done, budget);
        end
        checks++;
        if (exp_rd_q.size() + exp_wrc_q.size() + exp_wd_q.size() != 0) begin
            errors++;
            $display("FAIL run_drain: got %0d rd %0d wrcmd %0d beats outstanding, want 0",
                     exp_rd_q.size(), exp_wrc_q.size(), exp_wd_q.size());
        end
    endtask

    task automatic fill_src(input int src, input int len, input bit ramp);
        for (int i = 0; i < len; i++) mem[src + i] = ramp ? 8'(i) : 8'($urandom);
    endtask

    task automatic clear_dst(input int dst, input int len);
        for (int i = 0; i < len; i++) mem[dst + i] = 8'hEE;
    endtask

    function automatic logic [31:0] rd32(input int a);
        return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
    endfunction

    task automatic test_reset();
        axi_rst = 1'b1;
        repeat (3) @(negedge axi_clk);
        checks++;
        if (done !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: got done=%0b err=%0b, want done=1 err=0", done, err);
        end
        checks++;
        if ({rd_cmd_vld, wr_cmd_vld, wr_dat_vld} !== 3'b000) begin
            errors++;
            $display("FAIL reset_valids: got %b, want 000", {rd_cmd_vld, wr_cmd_vld, wr_dat_vld});
        end
        checks++;
        if (rd_cmd_addr !== '0 || wr_cmd_addr !== '0 || wr_dat !== '0) begin
            errors++;
            $display("FAIL reset_fields: got rd=%h wr=%h dat=%h, want 0", rd_cmd_addr, wr_cmd_addr, wr_dat);
        end
        axi_rst = 1'b0;
        @(negedge axi_clk);
    endtask

    task automatic test_small(input int mode, input logic [31:0] w0, input logic [31:0] w1);
        fill_src(32'h100, 8, 1'b1);
        clear_dst(32'h800, 8);
        launch(32'h100, 32'h800, 8, mode);
        wait_done(200);
        checks++;
        if (rd32(32'h800) !== w0 || rd32(32'h804) !== w1) begin
            errors++;
            $display("FAIL small_mode%0d: got %h %h, want %h %h", mode, rd32(32'h800), rd32(32'h804), w0, w1);
        end
    endtask

    task automatic test_multi_burst();
        int bad;
        fill_src(32'h1000, 72, 1'b0);
        clear_dst(32'h2000, 72);
        launch(32'h1000, 32'h2000, 72, 0);
        wait_done(500);
        bad = 0;
        for (int p = 0; p < 72; p++) if (mem[32'h2000 + p] !== mem[32'h1000 + 71 - p]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL multi_burst_bytes: got %0d wrong bytes, want 0", bad);
        end
    endtask

    task automatic test_reject();
        int lens [3] = '{6, 0, 8};
        int modes[3] = '{0, 0, 3};
        int cnt0;
        for (int t = 0; t < 3; t++) begin
            cnt0 = rd_cmd_cnt + wr_cmd_cnt;
            @(negedge axi_clk);
            cfg_src_base = 32'h100; cfg_dst_base = 32'h800;
            cfg_len = LEN_W'(lens[t]); cfg_mode = 2'(modes[t]); cfg_start = 1'b1;
            @(negedge axi_clk);
            cfg_start = 1'b0;
            checks++;
            if (err !== 1'b1 || done !== 1'b1) begin
                errors++;
                $display("FAIL reject%0d_pulse: got err=%0b done=%0b, want err=1 done=1", t, err, done);
            end
            @(negedge axi_clk);
            checks++;
            if (err !== 1'b0) begin
                errors++;
                $display("FAIL reject%0d_pulse_end: got err=%0b, want 0", t, err);
            end
            repeat (5) @(negedge axi_clk);
            checks++;
            if (rd_cmd_cnt + wr_cmd_cnt != cnt0 || rd_cmd_vld !== 1'b0 || done !== 1'b1) begin
                errors++;
                $display("FAIL reject%0d_quiet: got cmds=%0d vld=%0b done=%0b, want cmds=%0d vld=0 done=1",
                         t, rd_cmd_cnt + wr_cmd_cnt, rd_cmd_vld, done, cnt0);
            end
        end
    endtask

    task automatic test_backpressure();
        bp_en = 1'b1;
        fill_src(32'h1000, 2048, 1'b0);
        clear_dst(32'h2000, 2048);
        launch(32'h1000, 32'h2000, 2048, int'($urandom_range(0, 2)));
        repeat (40) @(negedge axi_clk);
        cfg_src_base = 32'h100; cfg_dst_base = 32'h800; cfg_len = 8; cfg_mode = 0; cfg_start = 1'b1;
        @(negedge axi_clk);
        cfg_start = 1'b0;
        checks++;
        if (err !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL busy_start: got err=%0b done=%0b, want err=0 done=0", err, done);
        end
        wait_done(20000);
        bp_en = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int base, i;
        fill_src(32'h1000, 72, 1'b0);
        base = wr_cmd_cnt;
        launch(32'h1000, 32'h3000, 72, 0);
        for (i = 0; i < 500; i++) begin
            @(posedge axi_clk);
            #2;
            if (wr_cmd_cnt == base + 2 && wr_dat_vld === 1'b1) break;
        end
        checks++;
        if (i == 500) begin
            errors++;
            $display("FAIL reset_mid_reach: got wr_cmds=%0d, want %0d with wr_dat_vld", wr_cmd_cnt - base, 2);
        end
        axi_rst = 1'b1;
        #1;
        checks++;
        if (done !== 1'b1 || {rd_cmd_vld, wr_cmd_vld, wr_dat_vld} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_outputs: got done=%0b vld=%b, want done=1 vld=000",
                     done, {rd_cmd_vld, wr_cmd_vld, wr_dat_vld});
        end
        repeat (2) @(negedge axi_clk);
        axi_rst = 1'b0;
        @(negedge axi_clk);
        clear_dst(32'h3000, 72);
        launch(32'h1000, 32'h3000, 72, 1);
        wait_done(500);
    endtask

    initial begin
        axi_rst = 1'b1; cfg_start = 1'b0; cfg_src_base = '0; cfg_dst_base = '0;
        cfg_len = '0; cfg_mode = '0;
        for (int i = 0; i < MEMSZ; i++) mem[i] = 8'h00;
        test_reset();
        test_small(0, 32'h04050607, 32'h00010203);
        test_small(1, 32'h05040706, 32'h01000302);
        test_small(2, 32'h07060504, 32'h03020100);
        test_multi_burst();
        test_reject();
        test_backpressure();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reverse_engine_param.md
Name: reverse_engine_param

Overview:
- Parametrised successor to the single-config reverse block.
- Reverses a buffer of cfg_len bytes from cfg_src_base into cfg_dst_base through a burst command/data memory port; reversal granularity (byte, halfword, word) is selectable per run.
- Data width and burst depth are generic. The tail of the source is fetched a burst at a time into a local buffer, then written forward to the destination.
- Sits between the register interface (start/done/len/base regs) and the SDRAM/AXI bridge.

Parameters:
DATA_W, 32, memory data width in bits; 32/64/128 (8*2^k, >=32); DB = DATA_W/8
ADDR_W, 32, byte address width
LEN_W, 24, byte length width
BURST, 16, max beats per command and local buffer depth in words; power of 2, >=2

Ports:
axi_clk  in  1  clock
axi_rst  in  1  asynchronous reset, active-high
cfg_start  in  1  single-cycle start pulse; ignored while busy
cfg_src_base  in  ADDR_W  source byte address, DB-aligned
cfg_dst_base  in  ADDR_W  destination byte address, DB-aligned
cfg_len  in  LEN_W  length in bytes
cfg_mode  in  2  0=byte, 1=halfword, 2=word element reversal, 3=reserved
done  out  1  high when idle; low while a run is active
err  out  1  one-cycle pulse on a rejected start
rd_cmd_vld  out  1  read command valid
rd_cmd_rdy  in  1  read command ready
rd_cmd_addr  out  ADDR_W  read burst start byte address
rd_cmd_len  out  log2(BURST)+1  read burst beats, 1..BURST
rd_dat_vld  in  1  read beat valid; always accepted, in order
rd_dat  in  DATA_W  read beat data
wr_cmd_vld  out  1  write command valid
wr_cmd_rdy  in  1  write command ready
wr_cmd_addr  out  ADDR_W  write burst start byte address
wr_cmd_len  out  log2(BURST)+1  write burst beats
wr_dat_vld  out  1  write beat valid
wr_dat_rdy  in  1  write beat ready
wr_dat  out  DATA_W  write beat data

Behaviour:
- Reset values: done=1; all other outputs 0; FSM=IDLE; counters 0.
- Start is captured in IDLE only; config regs are latched on the start cycle.
- Start is rejected when cfg_len==0, cfg_len%DB!=0, cfg_mode==3, or element bytes (1<<cfg_mode) > DB.
  - On reject: err=1 for the next cycle, done stays 1, no commands are issued.
- On an accepted start, done falls the next cycle.
- Setup: N = cfg_len/DB words; rem = N words not yet fetched; wcnt = 0 words written.
- FSM states and transitions:
  - IDLE -> RD_CMD on an accepted start.
  - RD_CMD: chunk = min(BURST, rem); rd_cmd_addr = src + (rem-chunk)*DB; rd_cmd_len = chunk. Hold vld and fields until rdy. -> RD_DAT.
  - RD_DAT: store beat i at buf[i]. After chunk beats, rem -= chunk. -> WR_CMD.
  - WR_CMD: wr_cmd_addr = dst + wcnt*DB; wr_cmd_len = chunk. Hold until rdy. -> WR_DAT.
  - WR_DAT: beat j carries buf[chunk-1-j] with its elements reversed within the word. Advance only on vld&rdy; hold data stable under backpressure. After chunk beats, wcnt += chunk.
    - rem>0 -> RD_CMD.
    - rem==0 -> IDLE, and done rises the cycle after the last beat handshake.
- wr_dat may be asserted in the cycle after the write command handshake, not before.
- Element reversal within a word: element k of E = DB>>mode elements moves to position E-1-k. Combined with word-order reversal, this yields full element reversal of the buffer.
- Last burst may be short (rem < BURST); the first read targets the highest-addressed chunk.
- Unexpected rd_dat_vld outside RD_DAT is ignored.
- cfg_start while busy is ignored, with no err.
- Address arithmetic is modulo 2^ADDR_W.
- Asynchronous reset mid-run: immediate return to reset values; any outstanding bus burst is abandoned.

Test Plan:
- Byte reverse: DATA_W=32, mode=0, len=8, src words 0x03020100, 0x07060504 -> one read (addr src, len 2); writes 0x04050607, 0x00010203 to dst; done 1->0->1.
- Halfword: same data, mode=1 -> dst bytes 06 07 04 05 02 03 00 01; mode=2 -> 04..07 00..03.
- Multi-burst: BURST=16, len=72 (18 words) -> reads (src+8, 16), (src+0, 2); writes (dst+0, 16), (dst+64, 2); 72-byte output equals byte-reversed input.
- Reject: len=6, or len=0, or mode=3 -> err one cycle, no rd/wr commands, done stays 1.
- Backpressure: random wr_dat_rdy/rd_cmd_rdy/wr_cmd_rdy at 30% duty, len=2048 -> wr_dat stable while vld&!rdy; output matches model; second start mid-run ignored.
- Reset mid-run: assert axi_rst during WR_DAT of burst 2 -> done=1, all vld=0 immediately; new start after release completes correctly.
